// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, scan codes and event type for the PS/2 keyboard controller
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int ACT_UP    = 0;
    localparam int ACT_LEFT  = 1;
    localparam int ACT_DOWN  = 2;
    localparam int ACT_RIGHT = 3;
    localparam int ACT_SPACE = 4;
    localparam int ACT_ENTER = 5;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // One-hot action bit for a decoded key; zero for keys that are not game actions.
    function automatic logic [5:0] act_mask(input logic ext, input logic [7:0] code);
        logic [5:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                SC_W:     m[ACT_UP]    = 1'b1;
                SC_A:     m[ACT_LEFT]  = 1'b1;
                SC_S:     m[ACT_DOWN]  = 1'b1;
                SC_D:     m[ACT_RIGHT] = 1'b1;
                SC_SPACE: m[ACT_SPACE] = 1'b1;
                SC_ENTER: m[ACT_ENTER] = 1'b1;
                default:  ;
            endcase
        end else begin
            case (code)
                SC_UP:    m[ACT_UP]    = 1'b1;
                SC_LEFT:  m[ACT_LEFT]  = 1'b1;
                SC_DOWN:  m[ACT_DOWN]  = 1'b1;
                SC_RIGHT: m[ACT_RIGHT] = 1'b1;
                default:  ;
            endcase
        end
        return m;
    endfunction
endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - first-word-fall-through key event FIFO with overflow pulse
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_valid,
    input  ps2_evt_t wr_data,
    output logic     rd_valid,
    input  logic     rd_ready,
    output ps2_evt_t rd_data,
    output logic     ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ps2_evt_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push;

    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    assign push     = wr_valid && (!full || pop);
    // Head is masked when empty so the outputs read 0 after reset.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= wr_valid && full && !pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ps2_kbd_controller.sv
// rtl/ps2_kbd_controller.sv - PS/2 keyboard receiver, prefix decoder, action vector and event FIFO
module ps2_kbd_controller
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [5:0] acoes,
    output logic       frame_err,
    output logic       fifo_ovf
);
    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, fall, data_s;
    ps2_state_t             state, state_n;
    logic [2:0]             bitcnt;
    logic [7:0]             shreg, byte_q;
    logic                   par, byte_vld, ext_f, brk_f;
    logic [WD_W-1:0]        wdog;
    logic                   timeout, frame_ok, err_c, emit;
    logic [5:0]             mask;
    ps2_evt_t               wr_evt, rd_evt;

    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev && !clk_sync[SYNC_STAGES-1];
    assign timeout  = (state != IDLE) && !fall && (wdog == WD_LAST);
    assign frame_ok = data_s && (^{shreg, par});

    // Synchronisers idle high so releasing reset never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_n = state;
        err_c   = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            err_c   = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE:    if (!data_s) state_n = DATA;
                DATA:    if (bitcnt == 3'd7) state_n = PARITY;
                PARITY:  state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    err_c   = !frame_ok;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            wdog      <= '0;
            byte_vld  <= 1'b0;
            byte_q    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            frame_err <= err_c;
            byte_vld  <= fall && (state == STOP) && frame_ok;
            wdog      <= (fall || state_n == IDLE) ? '0 : wdog + 1'b1;
            if (fall) begin
                case (state)
                    IDLE:   bitcnt <= '0;
                    DATA: begin
                        shreg  <= {data_s, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                    end
                    PARITY: par <= data_s;
                    STOP:   byte_q <= shreg;
                    default: ;
                endcase
            end
        end
    end

    assign emit   = byte_vld && (byte_q != SC_E0) && (byte_q != SC_F0);
    assign wr_evt = {ext_f, brk_f, byte_q};
    assign mask   = act_mask(ext_f, byte_q);

    // A watchdog abort leaves the prefix flags alone so a half-sent sequence can still complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
            acoes <= '0;
        end else if (byte_vld) begin
            if (byte_q == SC_E0) begin
                ext_f <= 1'b1;
            end else if (byte_q == SC_F0) begin
                brk_f <= 1'b1;
            end else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
                acoes <= brk_f ? (acoes & ~mask) : (acoes | mask);
            end
        end
    end

    ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (emit),
        .wr_data  (wr_evt),
        .rd_valid (evt_valid),
        .rd_ready (evt_ready),
        .rd_data  (rd_evt),
        .ovf      (fifo_ovf)
    );

    assign evt_code  = rd_evt.code;
    assign evt_ext   = rd_evt.ext;
    assign evt_break = rd_evt.brk;
endmodule

// File: tb/tb_ps2_kbd_controller.sv
// tb/tb_ps2_kbd_controller.sv - self-checking bench for ps2_kbd_controller against a key-event model
`timescale 1ns/1ps
module tb_ps2_kbd_controller;
    localparam int CLK_HZ     = 1_000_000;
    localparam int TIMEOUT_US = 200;
    localparam int TO_CYC     = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int DEPTH      = 8;
    localparam int SYNC       = 2;
    localparam int HALF       = 20;

    logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, evt_ready = 1'b0;
    logic       evt_valid, evt_ext, evt_break, frame_err, fifo_ovf;
    logic [7:0] evt_code;
    logic [5:0] acoes;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, fall_cyc = 0, rise_cyc = -1, err_cyc = -1, err_cnt = 0, ovf_cnt = 0;
    logic       prev_valid = 1'b0;
    logic [9:0] got_q[$], exp_q[$];
    logic       m_ext = 1'b0, m_brk = 1'b0;
    logic [5:0] m_acoes = '0;
    event       stop_fall_ev;

    logic [7:0] key_code [10] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h75, 8'h6B, 8'h72, 8'h74};
    logic       key_ext  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int         key_bit  [10] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3};

    ps2_kbd_controller #(
        .CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_break(evt_break), .acoes(acoes),
        .frame_err(frame_err), .fifo_ovf(fifo_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (evt_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = evt_valid;
        if (evt_valid && evt_ready) got_q.push_back({evt_ext, evt_break, evt_code});
        if (frame_err) begin err_cnt++; err_cyc = cyc; end
        if (fifo_ovf) ovf_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit");
    end

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            exp_q.push_back({m_ext, m_brk, b});
            for (int k = 0; k < 10; k++)
                if (key_code[k] == b && key_ext[k] == m_ext) m_acoes[key_bit[k]] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop, input int nbits);
        logic [10:0] bits;
        bits = {stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(posedge clk); #1;
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            if (i == 10) -> stop_fall_ev;
            repeat (HALF) @(posedge clk); #1;
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11);
        model_byte(b);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({evt_valid, evt_code, evt_ext, evt_break, acoes, frame_err, fifo_ovf} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {evt_valid, evt_code, evt_ext, evt_break, acoes, frame_err, fifo_ovf});
        end
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        n_checks++;
        if (evt_valid !== 1'b0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle: evt_valid %b errs %0d required 0 0", evt_valid, err_cnt);
        end
    endtask

    task automatic test_single;
        evt_ready = 1'b0;
        rise_cyc  = -1;
        send_byte(8'h1C);
        n_checks++;
        if (rise_cyc - fall_cyc != SYNC + 2) begin
            n_fail++;
            $display("FAIL latency: got %0d required %0d", rise_cyc - fall_cyc, SYNC + 2);
        end
        for (int t = 0; t < 2; t++) begin
            n_checks++;
            if ({evt_valid, evt_ext, evt_break, evt_code} !== {1'b1, exp_q[0]}) begin
                n_fail++;
                $display("FAIL single_head%0d: got %h required %h", t,
                         {evt_valid, evt_ext, evt_break, evt_code}, {1'b1, exp_q[0]});
            end
            repeat (10) @(posedge clk); #1;
        end
        n_checks++;
        if (acoes !== 6'b000010) begin
            n_fail++;
            $display("FAIL single_acoes: got %b required 000010", acoes);
        end
        evt_ready = 1'b1;
        @(posedge clk); #1;
        evt_ready = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0 || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL single_pop: valid %b popped %0d required 0 1", evt_valid, got_q.size());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_prefixes;
        evt_ready = 1'b1;
        send_byte(8'hF0); send_byte(8'h1C);
        n_checks++;
        if (acoes !== m_acoes || acoes[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL break_left: got %b required %b", acoes, m_acoes);
        end
        send_byte(8'hE0); send_byte(8'h74);
        n_checks++;
        if (acoes !== m_acoes || acoes[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL ext_make_right: got %b required %b", acoes, m_acoes);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        n_checks++;
        if (acoes !== m_acoes || acoes[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL ext_break_right: got %b required %b", acoes, m_acoes);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL prefix_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL prefix_evt%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_frame_errors;
        int e0;
        e0 = err_cnt;
        evt_ready = 1'b1;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        n_checks++;
        if (err_cnt != e0 + 1) begin
            n_fail++;
            $display("FAIL parity_err: got %0d pulses required 1", err_cnt - e0);
        end
        send_frame(8'h29, 1'b0, 1'b0, 11);
        n_checks++;
        if (err_cnt != e0 + 2) begin
            n_fail++;
            $display("FAIL stop_err: got %0d pulses required 2", err_cnt - e0);
        end
        n_checks++;
        if (got_q.size() != 0 || acoes !== m_acoes) begin
            n_fail++;
            $display("FAIL err_no_event: events %0d acoes %b required 0 %b", got_q.size(), acoes, m_acoes);
        end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b0, 1'b1, 5);
        repeat (TO_CYC + 20) @(posedge clk); #1;
        n_checks++;
        if (err_cnt != e0 + 1) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %0d pulses required 1", err_cnt - e0);
        end
        n_checks++;
        if (err_cyc - fall_cyc < TO_CYC || err_cyc - fall_cyc > TO_CYC + SYNC + 3) begin
            n_fail++;
            $display("FAIL timeout_time: got %0d cycles required %0d..%0d",
                     err_cyc - fall_cyc, TO_CYC, TO_CYC + SYNC + 3);
        end
        send_byte(8'h29);
        n_checks++;
        if (acoes !== m_acoes || acoes[4] !== 1'b1 || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL after_timeout: acoes %b events %0d required %b 1", acoes, got_q.size(), m_acoes);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow;
        int o0;
        logic [7:0] b;
        evt_ready = 1'b0;
        o0 = ovf_cnt;
        for (int i = 0; i <= DEPTH; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
            send_byte(b);
            if (i == DEPTH - 1) begin
                n_checks++;
                if (ovf_cnt != o0) begin
                    n_fail++;
                    $display("FAIL ovf_early: got %0d pulses required 0", ovf_cnt - o0);
                end
            end
        end
        void'(exp_q.pop_back());
        n_checks++;
        if (ovf_cnt != o0 + 1 || acoes !== m_acoes) begin
            n_fail++;
            $display("FAIL ovf_last: pulses %0d acoes %b required 1 %b", ovf_cnt - o0, acoes, m_acoes);
        end
        do b = 8'($urandom_range(0, 255)); while (b == 8'hE0 || b == 8'hF0);
        fork
            send_frame(b, 1'b0, 1'b1, 11);
            begin
                @(stop_fall_ev);
                repeat (SYNC + 1) @(posedge clk); #1;
                evt_ready = 1'b1;
                @(posedge clk); #1;
                evt_ready = 1'b0;
            end
        join
        model_byte(b);
        n_checks++;
        if (ovf_cnt != o0 + 1 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL full_push_pop: pulses %0d pops %0d required 1 1", ovf_cnt - o0, got_q.size());
        end
        evt_ready = 1'b1;
        repeat (DEPTH + 4) @(posedge clk); #1;
        n_checks++;
        if (got_q.size() != exp_q.size() || evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_drain: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL fifo_order%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        logic [7:0] c;
        logic       e, r;
        int         k;
        evt_ready = 1'b1;
        for (int n = 0; n < 15; n++) begin
            k = $urandom_range(0, 12);
            if (k < 10) begin
                c = key_code[k];
                e = key_ext[k];
            end else begin
                do c = 8'($urandom_range(0, 255)); while (c == 8'hE0 || c == 8'hF0);
                e = 1'($urandom_range(0, 1));
            end
            r = 1'($urandom_range(0, 1));
            if (e) send_byte(8'hE0);
            if (r) send_byte(8'hF0);
            send_byte(c);
            n_checks++;
            if (acoes !== m_acoes) begin
                n_fail++;
                $display("FAIL rand_acoes%0d: got %b required %b", n, acoes, m_acoes);
            end
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_evt%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midframe;
        evt_ready = 1'b0;
        send_byte(8'h1D);
        send_frame(8'h5A, 1'b0, 1'b1, 6);
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if ({evt_valid, evt_code, evt_ext, evt_break, acoes, frame_err, fifo_ovf} !== 19'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h required 0",
                     {evt_valid, evt_code, evt_ext, evt_break, acoes, frame_err, fifo_ovf});
        end
        rst_n = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_acoes = '0;
        got_q.delete();
        exp_q.delete();
        repeat (5) @(posedge clk); #1;
        evt_ready = 1'b1;
        send_byte(8'h5A);
        n_checks++;
        if (acoes !== m_acoes || acoes !== 6'b100000 || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL after_reset_enter: acoes %b events %0d required 100000 1", acoes, got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefixes();
        test_frame_errors();
        test_timeout();
        test_overflow();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
